accum_table_drain: RTL and testbench

ACCUM_TABLE_DRAIN -- requirements
Module: accum_table_drain

---
 rtl/accum_pkg.sv | 23 ++
 rtl/accum_table_drain_if.sv | 17 +
 rtl/accum_drain_skid.sv | 49 ++++
 rtl/accum_table_drain.sv | 152 +++++++++++++++
 tb/tb_accum_table_drain.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/accum_pkg.sv
// Shared constants, table address mapping and drain FSM states for the accumulator-table drain.
package accum_pkg;
  localparam int unsigned ACC_MAX_OUT_ROWS   = 128;
  localparam int unsigned ACC_MAX_OUT_COLS   = 128;
  localparam int unsigned ACC_SYS_ARR_COLS   = 16;
  localparam int unsigned ACC_DATA_WIDTH     = 32;
  localparam int unsigned ACC_NUM_SUBMATS_N  = ACC_MAX_OUT_COLS / ACC_SYS_ARR_COLS;
  localparam int unsigned ACC_NUM_ACCUM_ROWS = ACC_MAX_OUT_ROWS * ACC_NUM_SUBMATS_N;
  localparam int unsigned ACC_ADDR_WIDTH     = $clog2(ACC_NUM_ACCUM_ROWS);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} drain_state_e;

  // Index width that stays legal when a dimension collapses to a single entry.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Same (block,row) -> row-address mapping the write side uses.
  function automatic int unsigned accum_addr(input int unsigned blk, input int unsigned row,
                                             input int unsigned max_rows);
    return blk * max_rows + row;
  endfunction
endpackage

// File: rtl/accum_table_drain_if.sv
// Drained-row output stream: master produces beats, slave applies back-pressure via out_ready.
interface accum_table_drain_if #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SYS_ARR_COLS = 16,
  parameter int unsigned ROW_W        = 7,
  parameter int unsigned BLK_W        = 3
);
  logic                               out_valid;
  logic                               out_ready;
  logic [DATA_WIDTH*SYS_ARR_COLS-1:0] out_data;
  logic [ROW_W-1:0]                   out_row;
  logic [BLK_W-1:0]                   out_col_blk;
  logic                               out_last;

  modport master (output out_valid, out_data, out_row, out_col_blk, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_row, out_col_blk, out_last, output out_ready);
endinterface

// File: rtl/accum_drain_skid.sv
// Two-entry output buffer: entry 0 drives the stream, entry 1 absorbs a read that lands during a stall.
module accum_drain_skid #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);
  logic         r_v0, r_v1;
  logic [W-1:0] r_d0, r_d1;
  logic         w_pop;

  assign w_pop = r_v0 & i_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_d0 <= '0;
      r_d1 <= '0;
    end else if (w_pop) begin
      if (r_v1) begin
        r_d0 <= r_d1;
        r_v1 <= i_push;
        if (i_push) r_d1 <= i_push_data;
      end else begin
        r_v0 <= i_push;
        if (i_push) r_d0 <= i_push_data;
      end
    end else if (i_push) begin
      if (!r_v0) begin
        r_v0 <= 1'b1;
        r_d0 <= i_push_data;
      end else begin
        r_v1 <= 1'b1;
        r_d1 <= i_push_data;
      end
    end
  end

  assign o_valid = r_v0;
  assign o_data  = r_d0;
  assign o_count = {1'b0, r_v0} + {1'b0, r_v1};
endmodule

// File: rtl/accum_table_drain.sv
// Streams accumulator-table rows out block-major, row-minor, behind a 2-entry output buffer.
// Optional macro ACCUM_DRAIN_CLEAR_EN adds a zero-write port that clears each row as it is read.
module accum_table_drain
  import accum_pkg::*;
#(
  parameter int unsigned MAX_OUT_ROWS = ACC_MAX_OUT_ROWS,
  parameter int unsigned MAX_OUT_COLS = ACC_MAX_OUT_COLS,
  parameter int unsigned SYS_ARR_COLS = ACC_SYS_ARR_COLS,
  parameter int unsigned DATA_WIDTH   = ACC_DATA_WIDTH,
  localparam int unsigned NUM_SUBMATS_N  = MAX_OUT_COLS / SYS_ARR_COLS,
  localparam int unsigned NUM_ACCUM_ROWS = MAX_OUT_ROWS * NUM_SUBMATS_N,
  localparam int unsigned ADDR_WIDTH     = $clog2(NUM_ACCUM_ROWS),
  localparam int unsigned ROWS_W         = $clog2(MAX_OUT_ROWS) + 1,
  localparam int unsigned BLKS_W         = $clog2(NUM_SUBMATS_N) + 1,
  localparam int unsigned ROW_W          = idx_w(MAX_OUT_ROWS),
  localparam int unsigned BLK_W          = idx_w(NUM_SUBMATS_N),
  localparam int unsigned ROW_BITS       = DATA_WIDTH * SYS_ARR_COLS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ROWS_W-1:0]     num_rows,
  input  logic [BLKS_W-1:0]     num_col_blks,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [ROW_BITS-1:0]   rd_data,
  accum_table_drain_if.master   out_if
`ifdef ACCUM_DRAIN_CLEAR_EN
  ,
  output logic                  clr_en,
  output logic [ADDR_WIDTH-1:0] clr_addr
`endif
);
  localparam int unsigned PW = 1 + BLK_W + ROW_W + ROW_BITS;

  drain_state_e      r_state;
  logic [ROWS_W-1:0] r_rows;
  logic [BLKS_W-1:0] r_blks;
  logic [ROW_W-1:0]  r_row, r_fl_row;
  logic [BLK_W-1:0]  r_blk, r_fl_blk;
  logic              r_busy, r_done, r_fl_vld, r_fl_last;

  logic [ROWS_W-1:0] w_rows_clamp;
  logic [BLKS_W-1:0] w_blks_clamp;
  logic              w_row_end, w_blk_end, w_rd_en, w_pop, w_out_valid;
  logic [1:0]        w_count;
  logic [2:0]        w_commit;
  logic [PW-1:0]     w_out_pl;

  assign w_rows_clamp = (num_rows > ROWS_W'(MAX_OUT_ROWS)) ? ROWS_W'(MAX_OUT_ROWS) : num_rows;
  assign w_blks_clamp = (num_col_blks > BLKS_W'(NUM_SUBMATS_N)) ? BLKS_W'(NUM_SUBMATS_N) : num_col_blks;
  assign w_row_end    = ({1'b0, r_row} == r_rows - ROWS_W'(1));
  assign w_blk_end    = ({1'b0, r_blk} == r_blks - BLKS_W'(1));

  // Slots committed after this edge: buffered + in flight, minus the beat leaving now.
  // Counting the departing beat keeps one read per cycle flowing while out_ready stays high.
  assign w_pop    = w_out_valid & out_if.out_ready;
  assign w_commit = {1'b0, w_count} + {2'b0, r_fl_vld} - {2'b0, w_pop};
  assign w_rd_en  = reset & (r_state == READ) & (w_commit < 3'd2);

  assign rd_en   = w_rd_en;
  assign rd_addr = ADDR_WIDTH'(accum_addr(32'(r_blk), 32'(r_row), MAX_OUT_ROWS));
  assign busy    = r_busy;
  assign done    = r_done;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rows    <= '0;
      r_blks    <= '0;
      r_row     <= '0;
      r_blk     <= '0;
      r_fl_vld  <= 1'b0;
      r_fl_last <= 1'b0;
      r_fl_row  <= '0;
      r_fl_blk  <= '0;
    end else begin
      r_fl_vld <= w_rd_en;
      if (w_rd_en) begin
        r_fl_row  <= r_row;
        r_fl_blk  <= r_blk;
        r_fl_last <= w_row_end & w_blk_end;
      end
      case (r_state)
        IDLE, DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          if (start) begin
            r_rows <= w_rows_clamp;
            r_blks <= w_blks_clamp;
            r_row  <= '0;
            r_blk  <= '0;
            if ((w_rows_clamp == '0) || (w_blks_clamp == '0)) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= READ;
              r_busy  <= 1'b1;
            end
          end
        end
        READ: begin
          if (w_rd_en) begin
            if (w_row_end) begin
              r_row <= '0;
              if (w_blk_end) begin
                r_blk   <= '0;
                r_state <= FLUSH;
              end else begin
                r_blk <= r_blk + BLK_W'(1);
              end
            end else begin
              r_row <= r_row + ROW_W'(1);
            end
          end
        end
        FLUSH: begin
          if (w_commit == 3'd0) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  accum_drain_skid #(.W(PW)) u_skid (
    .clk         (clk),
    .reset       (reset),
    .i_push      (r_fl_vld),
    .i_push_data ({r_fl_last, r_fl_blk, r_fl_row, rd_data}),
    .i_ready     (out_if.out_ready),
    .o_valid     (w_out_valid),
    .o_data      (w_out_pl),
    .o_count     (w_count)
  );

  assign out_if.out_valid = w_out_valid;
  assign {out_if.out_last, out_if.out_col_blk, out_if.out_row, out_if.out_data} = w_out_pl;

`ifdef ACCUM_DRAIN_CLEAR_EN
  assign clr_en   = w_rd_en;
  assign clr_addr = rd_addr;
`endif
endmodule

// File: tb/tb_accum_table_drain.sv
// Randomized bench for accum_table_drain against a queue-based model of the drain order and table contents.
`timescale 1ns/1ps
module tb_accum_table_drain;
  localparam int ROWS = 128, BLKS = 8, ROW_BITS = 512, AW = 10;

  typedef struct {int row; int blk; bit last;} beat_t;

  logic                clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [7:0]          num_rows = '0;
  logic [3:0]          num_col_blks = '0;
  logic                busy, done, rd_en;
  logic [AW-1:0]       rd_addr;
  logic [ROW_BITS-1:0] rd_data = '0;
`ifdef ACCUM_DRAIN_CLEAR_EN
  logic                clr_en;
  logic [AW-1:0]       clr_addr;
`endif

  accum_table_drain_if out_if ();

  accum_table_drain dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_rows     (num_rows),
    .num_col_blks (num_col_blks),
    .busy         (busy),
    .done         (done),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .out_if       (out_if)
`ifdef ACCUM_DRAIN_CLEAR_EN
    ,
    .clr_en       (clr_en),
    .clr_addr     (clr_addr)
`endif
  );

  always #5 clk = ~clk;

  int unsigned salt;
  int          cyc = 0, n_tests = 0, n_fail = 0;
  int          exp_addr_q[$];
  beat_t       exp_beat_q[$];
  int          n_rd, n_beat, first_rd, last_rd, first_vld, last_beat, done_cyc, ready_mode;
  bit          busy_seen, last_seen, prev_stall;
  logic [ROW_BITS-1:0] prev_data;

  function automatic logic [ROW_BITS-1:0] mem_word(input logic [AW-1:0] a);
    logic [ROW_BITS-1:0] w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = ({22'd0, a} * 32'h9E3779B1) ^ (32'(i) << 24) ^ salt;
    return w;
  endfunction

  // Table model: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_data <= rd_en ? mem_word(rd_addr) : ~mem_word(rd_addr);
  end

  task automatic check(input string tag, input logic [ROW_BITS-1:0] obs, input logic [ROW_BITS-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    beat_t b;
    int    ea;
    if (reset) begin
      if (rd_en) begin
        n_rd++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        check("rd_busy", busy, 1);
        if (exp_addr_q.size() == 0) check("rd_spurious", 1, 0);
        else begin
          ea = exp_addr_q.pop_front();
          check("rd_addr", rd_addr, ea);
`ifdef ACCUM_DRAIN_CLEAR_EN
          check("clr_addr", clr_addr, ea);
`endif
        end
      end
`ifdef ACCUM_DRAIN_CLEAR_EN
      check("clr_en", clr_en, rd_en);
`endif
      if (prev_stall) begin
        check("hold_valid", out_if.out_valid, 1);
        check("hold_data", out_if.out_data, prev_data);
      end
      if (out_if.out_valid && first_vld < 0) first_vld = cyc;
      if (out_if.out_valid && out_if.out_ready) begin
        n_beat++;
        last_beat = cyc;
        if (out_if.out_last) last_seen = 1;
        if (exp_beat_q.size() == 0) check("beat_spurious", 1, 0);
        else begin
          b = exp_beat_q.pop_front();
          check("beat_row", out_if.out_row, b.row);
          check("beat_blk", out_if.out_col_blk, b.blk);
          check("beat_last", out_if.out_last, b.last);
          check("beat_data", out_if.out_data, mem_word(AW'(b.blk * ROWS + b.row)));
        end
      end
      if (rd_en) check("outstanding_le2", ((n_rd - n_beat) <= 2), 1);
      if (busy) busy_seen = 1;
      if (done && done_cyc < 0) done_cyc = cyc;
      prev_stall = out_if.out_valid && !out_if.out_ready;
      prev_data  = out_if.out_data;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic clr_trk();
    n_rd = 0; n_beat = 0; first_rd = -1; last_rd = -1; first_vld = -1;
    last_beat = -1; done_cyc = -1; busy_seen = 0; last_seen = 0;
  endtask

  task automatic enq(input int rows, input int blks);
    int r, b;
    beat_t e;
    r = (rows > ROWS) ? ROWS : rows;
    b = (blks > BLKS) ? BLKS : blks;
    for (int bk = 0; bk < b; bk++)
      for (int rw = 0; rw < r; rw++) begin
        e.row = rw; e.blk = bk; e.last = (bk == b - 1) && (rw == r - 1);
        exp_addr_q.push_back(bk * ROWS + rw);
        exp_beat_q.push_back(e);
      end
  endtask

  task automatic drive_ready();
    case (ready_mode)
      0:       out_if.out_ready = 1'b1;
      1:       out_if.out_ready = !out_if.out_ready;
      default: out_if.out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic pulse_start(input int rows, input int blks, output int st);
    num_rows = 8'(rows); num_col_blks = 4'(blks); start = 1'b1; drive_ready();
    @(posedge clk); #1;
    start = 1'b0; st = cyc; drive_ready();
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cyc < 0 && k < budget) begin @(posedge clk); #1; drive_ready(); k++; end
    if (done_cyc < 0) check("done_timeout", 0, 1);
  endtask

  task automatic end_checks(input int total, input int st, input bit burst);
    check("beats_left", exp_beat_q.size(), 0);
    check("addrs_left", exp_addr_q.size(), 0);
    check("n_rd", n_rd, total);
    check("n_beat", n_beat, total);
    check("done_is_pulse", done, 0);
    check("busy_after", busy, 0);
    if (total == 0) begin
      check("zero_done_cyc", done_cyc, st);
      check("zero_busy", busy_seen, 0);
    end else begin
      check("done_after_last", done_cyc, last_beat + 1);
      check("rd_latency", first_rd, st);
      check("vld_latency", first_vld, st + 2);
      if (burst) begin
        check("rd_burst", last_rd - first_rd, total - 1);
        check("no_bubble", last_beat - first_vld, total - 1);
      end
    end
  endtask

  task automatic run(input int rows, input int blks, input int mode, input bit burst);
    int st, total;
    ready_mode = mode;
    clr_trk();
    enq(rows, blks);
    total = exp_beat_q.size();
    pulse_start(rows, blks, st);
    wait_done(3000 + 4 * total);
    end_checks(total, st, burst);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_valid"}, out_if.out_valid, 0);
    check({tag, "_last"}, out_if.out_last, 0);
    check({tag, "_data"}, out_if.out_data, 0);
    check({tag, "_row"}, out_if.out_row, 0);
    check({tag, "_blk"}, out_if.out_col_blk, 0);
`ifdef ACCUM_DRAIN_CLEAR_EN
    check({tag, "_clr_en"}, clr_en, 0);
    check({tag, "_clr_addr"}, clr_addr, 0);
`endif
  endtask

  initial begin
    int st, k;
    salt = $urandom;
    out_if.out_ready = 1'b0;
    ready_mode = 0;
    clr_trk();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    run(4, 2, 0, 1);
    run(8, 1, 1, 0);
    run(0, 1, 0, 0);
    run(3, 0, 0, 0);

    // Reset while the fifth beat is on the bus, then drain again from scratch.
    ready_mode = 0; clr_trk(); enq(16, 1); pulse_start(16, 1, st);
    k = 0;
    while (n_beat < 4 && k < 100) begin @(posedge clk); #1; k++; end
    check("beat5_row", out_if.out_row, 4);
    reset = 1'b0;
    @(posedge clk); #1;
    chk_zero("midreset");
    reset = 1'b1;
    exp_addr_q.delete(); exp_beat_q.delete();
    run(16, 1, 0, 1);

    // Start while busy is ignored.
    ready_mode = 0; clr_trk(); enq(6, 1); pulse_start(6, 1, st);
    @(posedge clk); #1;
    num_rows = 8'd5; num_col_blks = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200);
    end_checks(6, st, 1);

    // Start in the DONE cycle chains straight into a new drain.
    clr_trk(); enq(3, 2); pulse_start(3, 2, st);
    k = 0;
    while (!last_seen && k < 200) begin @(posedge clk); #1; k++; end
    check("done_at_restart", done, 1);
    enq(2, 2);
    num_rows = 8'd2; num_col_blks = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; st = cyc; clr_trk();
    wait_done(200);
    end_checks(4, st, 1);

    for (int t = 0; t < 8; t++)
      run($urandom_range(1, 12), $urandom_range(1, 3), $urandom_range(0, 2), 0);
    run(200, 9, 0, 1);
    run($urandom_range(1, 5), 15, 2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
